// File: rtl/tape_in.sv
// tape_in: synchronises and debounces TAPE_IN, detects filtered rising edges,
// measures the edge-to-edge period in ce ticks and tracks tape activity.
module tape_in #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 8,
  parameter int PW_W         = 12,
  parameter int IDLE_TIMEOUT = 4000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            ce_sample,
  input  logic            enable,
  input  logic            tape_raw,
  output logic            tape_bit,
  output logic            edge_stb,
  output logic [PW_W-1:0] last_period,
  output logic            period_valid,
  output logic            active,
  output logic [7:0]      edge_count
);
  localparam int IW = $clog2(FILT_LEN + 1);
  localparam logic [IW-1:0] FILT_MAX = IW'(FILT_LEN);
  localparam logic [PW_W-1:0] TIMEOUT = PW_W'(IDLE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [IW-1:0] integ_q, integ_d;
  logic [PW_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [7:0] ecnt_q, ecnt_d;
  logic tape_bit_q, tape_bit_d, edge_stb_q, edge_stb_d, pv_q, pv_d, active_q, active_d;
  logic s, rise;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], tape_raw};
    integ_d = integ_q;
    tape_bit_d = tape_bit_q;
    state_d = state_q;
    cnt_d = cnt_q;
    period_d = period_q;
    ecnt_d = ecnt_q;
    active_d = active_q;
    if (ce_sample) begin
      integ_d = s ? ((integ_q == FILT_MAX) ? integ_q : integ_q + 1'b1)
                  : ((integ_q == '0) ? integ_q : integ_q - 1'b1);
      tape_bit_d = (integ_d == FILT_MAX) ? 1'b1 : (integ_d == '0) ? 1'b0 : tape_bit_q;
    end
    rise = ce_sample & ~tape_bit_q & tape_bit_d;
    edge_stb_d = rise;
    pv_d = rise && state_q != IDLE;
    if (rise) begin
      cnt_d = '0;
      ecnt_d = ecnt_q + 8'd1;
      state_d = (state_q == IDLE) ? ARMED : RUN;
      if (state_q != IDLE) begin
        period_d = cnt_q + 1'b1;
        active_d = 1'b1;
      end
    end else if (ce_sample && state_q != IDLE) begin
      // A rise on the timeout tick is handled above, so it always wins.
      if (cnt_q == TIMEOUT) begin
        state_d = IDLE;
        cnt_d = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!enable) begin
      sync_d = '0;
      integ_d = '0;
      tape_bit_d = 1'b0;
      state_d = IDLE;
      cnt_d = '0;
      period_d = '0;
      ecnt_d = '0;
      active_d = 1'b0;
      edge_stb_d = 1'b0;
      pv_d = 1'b0;
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      integ_q <= '0;
      tape_bit_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      period_q <= '0;
      ecnt_q <= '0;
      active_q <= 1'b0;
      edge_stb_q <= 1'b0;
      pv_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      integ_q <= integ_d;
      tape_bit_q <= tape_bit_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      ecnt_q <= ecnt_d;
      active_q <= active_d;
      edge_stb_q <= edge_stb_d;
      pv_q <= pv_d;
    end
  end
  assign tape_bit = tape_bit_q;
  assign edge_stb = edge_stb_q;
  assign last_period = period_q;
  assign period_valid = pv_q;
  assign active = active_q;
  assign edge_count = ecnt_q;
endmodule

// File: tb/tb_tape_in.sv
// tb_tape_in: scoreboard bench for tape_in with FILT_LEN=4, IDLE_TIMEOUT=20, ce every clk.
module tb_tape_in;
  localparam int PW = 12;
  logic clk = 0, reset_n = 0, ce_sample = 1, enable = 0, tape_raw = 0;
  logic tape_bit, edge_stb, period_valid, active;
  logic [PW-1:0] last_period;
  logic [7:0] edge_count;
  int n_chk = 0, n_err = 0, cyc = 0, edge_cyc = 0, n_edge = 0, n_pv = 0, save = 0;
  logic prev_es = 0, prev_pv = 0;
  int exp_q[$];
  tape_in #(.SYNC_STAGES(2), .FILT_LEN(4), .PW_W(PW), .IDLE_TIMEOUT(20)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_sample(ce_sample), .enable(enable),
    .tape_raw(tape_raw), .tape_bit(tape_bit), .edge_stb(edge_stb),
    .last_period(last_period), .period_valid(period_valid), .active(active),
    .edge_count(edge_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input int hi, input int lo);
    tape_raw = 1;
    ticks(hi);
    tape_raw = 0;
    ticks(lo);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_bit"}, tape_bit, 0);
    chk({tag, "_stb"}, edge_stb, 0);
    chk({tag, "_pv"}, period_valid, 0);
    chk({tag, "_act"}, active, 0);
    chk({tag, "_per"}, last_period, 0);
    chk({tag, "_ecnt"}, edge_count, 0);
  endtask
  always @(negedge clk) if (reset_n) begin
    if (edge_stb) begin
      n_edge++;
      edge_cyc = cyc;
      chk("edge_stb_width", prev_es, 0);
    end
    if (period_valid) begin
      n_pv++;
      chk("pv_width", prev_pv, 0);
      chk("pv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("pv_period", last_period, exp_q.pop_front());
    end
    prev_es = edge_stb;
    prev_pv = period_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tape_raw = 1;
    enable = 1;
    ticks(2);
    all_zero("reset");
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_hold", tape_bit, 0);
    end
    @(negedge clk);
    chk("t1_rise", tape_bit, 1);
    ticks(3);
    chk("t1_edges", n_edge, 1);
    chk("t1_ecnt", edge_count, 1);
    chk("t1_active", active, 0);
    tape_raw = 0;
    ticks(40);
    pulse(3, 20);
    chk("t2_glitch_edges", n_edge, 1);
    chk("t2_glitch_ecnt", edge_count, 1);
    pulse(4, 20);
    chk("t2_pulse4_edges", n_edge, 2);
    chk("t2_pulse4_ecnt", edge_count, 2);
    ticks(30);
    chk("t2_no_pv", n_pv, 0);
    pulse(10, 10);
    chk("t3_arm_no_pv", n_pv, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(20);
      pulse(10, 10);
    end
    chk("t3_pv_count", n_pv, 3);
    chk("t3_active", active, 1);
    chk("t3_period", last_period, 20);
    for (int i = 0; i < 40 && cyc != edge_cyc + 20; i++) @(negedge clk);
    chk("t4_wait", cyc, edge_cyc + 20);
    chk("t4_active_hold", active, 1);
    @(negedge clk);
    chk("t4_active_drop", active, 0);
    chk("t4_period_kept", last_period, 20);
    save = n_pv;
    pulse(10, 10);
    chk("t4_idle_rise_no_pv", n_pv, save);
    exp_q.push_back(20);
    pulse(10, 11);
    exp_q.push_back(21);
    tape_raw = 1;
    ticks(8);
    chk("t5_pv_count", n_pv, save + 2);
    chk("t5_period", last_period, 21);
    chk("t5_active", active, 1);
    chk("t5_bit", tape_bit, 1);
    #2 reset_n = 0;
    #1 all_zero("t6_async");
    @(negedge clk);
    reset_n = 1;
    tape_raw = 0;
    ticks(10);
    pulse(10, 10);
    exp_q.push_back(20);
    tape_raw = 1;
    ticks(8);
    chk("t6_run_active", active, 1);
    enable = 0;
    @(posedge clk);
    #1 all_zero("t6_enable");
    @(negedge clk);
    enable = 1;
    save = n_pv;
    ticks(10);
    tape_raw = 0;
    ticks(10);
    chk("t6_reenable_arm", n_pv, save);
    chk("t6_reenable_ecnt", edge_count, 1);
    exp_q.push_back(20);
    pulse(10, 10);
    chk("t6_reenable_pv", n_pv, save + 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
